uart_tx_buffer: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_fifo.sv | 78 +++++++
 rtl/uart_tx_buffer.sv | 131 +++++++++++++
 tb/tb_uart_tx_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-buffer FSM states and default baud timing.
package uart_pkg;

    localparam int unsigned UART_CLK_FREQ    = 1000000;
    localparam int unsigned UART_BAUD        = 9600;
    // Round up so the baud-domain transmitter always sees at least one full bit period of newd.
    localparam int unsigned UART_NEWD_CYCLES = (UART_CLK_FREQ + UART_BAUD - 1) / UART_BAUD;
    localparam int unsigned UART_DATA_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } txbuf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered full/empty/count.
// Pointers carry one extra MSB so they wrap naturally on a power-of-two depth.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [CW-1:0]          count
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q;
    logic [AW:0]            rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic                   full_q;
    logic                   empty_q;
    logic                   push_ok;
    logic                   pop_ok;

    // A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
    assign push_ok = push && (!full_q || pop);
    assign pop_ok  = pop && !empty_q;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter one byte at a time.
// Optional feature macro: UART_TXBUF_OVF_EN enables the sticky overflow flag.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned NEWD_CYCLES = UART_NEWD_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         newd,
    output logic [7:0]                   dintx,
    input  logic                         donetx,
    output logic                         overflow,
    output logic                         busy
);

    localparam int unsigned HW = $clog2(NEWD_CYCLES + 1);

    txbuf_state_t    state_q;
    logic [HW-1:0]   hold_q;
    logic            newd_q;
    logic [7:0]      dintx_q;
    logic            busy_q;
    logic            donetx_q;
    logic            done_seen_q;
    logic            done_rise;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_rd_data;

    assign done_rise = donetx && !donetx_q;
    // Pops happen only from IDLE, so bytes leave strictly in push order.
    assign pop       = (state_q == IDLE) && !fifo_empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Launch sequencer: pop, hold newd for NEWD_CYCLES, then wait for a fresh donetx edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            newd_q      <= 1'b0;
            dintx_q     <= '0;
            busy_q      <= 1'b0;
            donetx_q    <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            donetx_q <= donetx;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        dintx_q     <= fifo_rd_data;
                        newd_q      <= 1'b1;
                        hold_q      <= HW'(NEWD_CYCLES - 1);
                        done_seen_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // A completion edge arriving while newd is still high must not be lost.
                    if (done_rise) begin
                        done_seen_q <= 1'b1;
                    end
                    if (hold_q == '0) begin
                        newd_q  <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                WAIT: begin
                    // Only an edge counts; a level left over from the previous byte is ignored.
                    if (done_rise || done_seen_q) begin
                        done_seen_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    newd_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXBUF_OVF_EN
    logic ovf_q;

    // Sticky flag for a push dropped because the FIFO was full and nothing was popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (wr_en && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign full  = fifo_full;
    assign empty = fifo_empty;
    assign newd  = newd_q;
    assign dintx = dintx_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: expected bytes queued at push, checked at each newd rise.
module tb_uart_tx_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned NC    = 105;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       newd;
    logic [7:0] dintx;
    logic       donetx;
    logic       overflow;
    logic       busy;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_q [$];
    logic       newd_prev;
    int         hi_len;
    logic       exp_ovf;

    uart_tx_buffer #(
        .DEPTH       (DEPTH),
        .NEWD_CYCLES (NC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .newd     (newd),
        .dintx    (dintx),
        .donetx   (donetx),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Launch monitor: check each launched byte against the scoreboard and the newd width.
    always @(negedge clk) begin
        if (!rst) begin
            newd_prev = 1'b0;
            hi_len    = 0;
        end else begin
            if (newd && !newd_prev) begin
                if (exp_q.size() == 0) begin
                    chk("sb_size_at_launch", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("dintx", 32'(dintx), 32'(exp_q.pop_front()));
                end
                hi_len = 0;
            end
            if (newd) hi_len++;
            if (!newd && newd_prev) chk("newd_len", 32'(hi_len), 32'(NC));
            newd_prev = newd;
        end
    end

    task automatic push(input logic [7:0] b, input bit expect_kept);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_kept) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_newd(input logic level, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (newd === level) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("tmo_newd", 32'(newd), 32'(level));
    endtask

    // Play the transmitter for n launches: done pulse a few cycles after newd drops.
    task automatic serve(input int n);
        donetx = 1'b0;
        for (int k = 0; k < n; k++) begin
            wait_newd(1'b1, 400);
            wait_newd(1'b0, 400);
            repeat (3) @(negedge clk);
            donetx = 1'b1;
            repeat (3) @(negedge clk);
            donetx = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        newd_prev = 1'b0;
        hi_len    = 0;
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        donetx    = 1'b0;
`ifdef UART_TXBUF_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_newd", 32'(newd), 32'd0);
        chk("rst_dintx", 32'(dintx), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: launch latency 2 cycles
        push(8'h55, 1'b1);
        chk("push_count", 32'(count), 32'd1);
        chk("push_newd_early", 32'(newd), 32'd0);
        @(negedge clk);
        chk("launch_newd", 32'(newd), 32'd1);
        chk("launch_count", 32'(count), 32'd0);
        chk("launch_busy", 32'(busy), 32'd1);
        serve(1);
        chk("single_idle", 32'(busy), 32'd0);
        chk("single_empty", 32'(empty), 32'd1);

        // Burst to full during a launch, then overflow push
        push(8'hE0, 1'b1);
        wait_newd(1'b1, 10);
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_count", 32'(count), 32'd16);
        push(8'hAA, 1'b0);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'(exp_ovf));
        serve(17);
        chk("burst_empty", 32'(empty), 32'd1);
        chk("burst_idle", 32'(busy), 32'd0);

        // Stale donetx level across WAIT entry
        donetx = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h77, 1'b1);
        wait_newd(1'b1, 10);
        wait_newd(1'b0, 400);
        repeat (5) @(negedge clk);
        chk("stale_wait_busy", 32'(busy), 32'd1);
        donetx = 1'b0;
        repeat (2) @(negedge clk);
        donetx = 1'b1;
        repeat (2) @(negedge clk);
        chk("fresh_edge_idle", 32'(busy), 32'd0);
        donetx = 1'b0;
        repeat (2) @(negedge clk);

        // Done edge during LAUNCH: WAIT exits on its first cycle
        push(8'h99, 1'b1);
        wait_newd(1'b1, 10);
        repeat (10) @(negedge clk);
        donetx = 1'b1;
        repeat (3) @(negedge clk);
        donetx = 1'b0;
        wait_newd(1'b0, 400);
        chk("early_done_wait", 32'(busy), 32'd1);
        @(negedge clk);
        chk("early_done_idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // Push while full in the same cycle as an IDLE pop
        push(8'hB0, 1'b1);
        wait_newd(1'b1, 10);
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i), 1'b1);
        chk("pp_full_pre", 32'(count), 32'd16);
        wait_newd(1'b0, 400);
        donetx = 1'b1;
        @(negedge clk);
        push(8'hDD, 1'b1);
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_ovf_kept", 32'(overflow), 32'(exp_ovf));
        donetx = 1'b0;
        serve(17);
        chk("pp_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-LAUNCH with 5 bytes queued
        push(8'h10, 1'b1);
        wait_newd(1'b1, 10);
        for (int i = 0; i < 5; i++) push(8'h20 + 8'(i), 1'b1);
        repeat (3) @(negedge clk);
        chk("pre_rst_count", 32'(count), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_newd", 32'(newd), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_dintx", 32'(dintx), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ovf", 32'(overflow), 32'd0);
        push(8'h3C, 1'b1);
        @(negedge clk);
        chk("post_rst_launch", 32'(newd), 32'd1);
        serve(1);
        chk("post_rst_idle", 32'(busy), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
